// File: rtl/note_octave_seg_pkg.sv
// note_seg_pkg: seven-segment codes {g,f,e,d,c,b,a} for note letters and octave digits
package note_seg_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;
  localparam logic [SEG_W-1:0] SEG_G = 7'h3D;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

  function automatic logic [SEG_W-1:0] note_to_seg(input logic [2:0] idx);
    case (idx)
      3'd0:    return SEG_C;
      3'd1:    return SEG_D;
      3'd2:    return SEG_E;
      3'd3:    return SEG_F;
      3'd4:    return SEG_G;
      3'd5:    return SEG_A;
      3'd6:    return SEG_B;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [SEG_W-1:0] digit_to_seg(input logic [3:0] n);
    case (n)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/note_octave_seg_if.sv
// note_octave_seg_if: panel inputs (keys, octave buttons) and display/tone-generator outputs
interface note_octave_seg_if;
  import note_seg_pkg::*;
  logic [6:0]       key;
  logic             up;
  logic             down;
  logic [SEG_W-1:0] seg_note;
  logic [SEG_W-1:0] seg_oct;
  logic             note_valid;
  logic [2:0]       note_idx;
  logic [3:0]       octave;
  modport master (output key, up, down, input seg_note, seg_oct, note_valid, note_idx, octave);
  modport slave  (input key, up, down, output seg_note, seg_oct, note_valid, note_idx, octave);
endinterface

// File: rtl/note_octave_seg_btn_debounce.sv
// btn_debounce: synchronise an async button, debounce it, pulse rise on a debounced 0->1 flip
module btn_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DB_CYCLES);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   w_diff;
  logic                   w_flip;
  assign w_diff = r_sync[SYNC_STAGES-1] ^ r_level;
  assign w_flip = w_diff && (r_cnt == CW'(DB_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], din};
      r_cnt   <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
      r_level <= r_level ^ w_flip;
      r_rise  <= w_flip & ~r_level;
    end
  end
  assign level = r_level;
  assign rise  = r_rise;
endmodule

// File: rtl/note_octave_seg.sv
// note_octave_seg: synced note keys + debounced octave buttons driving two registered 7-seg digits
// Define OCT_WRAP_EN to make the octave wrap between OCT_MIN and OCT_MAX instead of saturating.
module note_octave_seg
  import note_seg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 65536,
  parameter int OCT_MIN     = 0,
  parameter int OCT_MAX     = 7,
  parameter int OCT_INIT    = 4
) (
  input logic               clk,
  input logic               rst,
  note_octave_seg_if.slave  bus
);
  localparam logic [3:0] L_MIN  = 4'(OCT_MIN);
  localparam logic [3:0] L_MAX  = 4'(OCT_MAX);
  localparam logic [3:0] L_INIT = 4'(OCT_INIT);
  logic [SYNC_STAGES-1:0][6:0] r_key_sync;
  logic [6:0]       w_key;
  logic [2:0]       w_idx;
  logic             r_note_valid;
  logic [2:0]       r_note_idx;
  logic [SEG_W-1:0] r_seg_note;
  logic [3:0]       r_oct;
  logic [3:0]       w_oct_nxt;
  logic [SEG_W-1:0] r_seg_oct;
  logic             w_up_rise;
  logic             w_dn_rise;
  logic             w_up_level_unused;
  logic             w_dn_level_unused;
  logic             w_up_ev;
  logic             w_dn_ev;
  assign w_key = r_key_sync[SYNC_STAGES-1];
  // Scan from B down to C so the lowest pressed key wins.
  always_comb begin
    w_idx = '0;
    for (int i = 6; i >= 0; i--) w_idx = w_key[i] ? 3'(i) : w_idx;
  end
  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_up (
    .clk(clk), .rst(rst), .din(bus.up), .level(w_up_level_unused), .rise(w_up_rise)
  );
  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_dn (
    .clk(clk), .rst(rst), .din(bus.down), .level(w_dn_level_unused), .rise(w_dn_rise)
  );
  assign w_up_ev = w_up_rise & ~w_dn_rise;
  assign w_dn_ev = w_dn_rise & ~w_up_rise;
`ifdef OCT_WRAP_EN
  assign w_oct_nxt = w_up_ev ? ((r_oct == L_MAX) ? L_MIN : r_oct + 4'd1) :
                     w_dn_ev ? ((r_oct == L_MIN) ? L_MAX : r_oct - 4'd1) : r_oct;
`else
  assign w_oct_nxt = w_up_ev ? ((r_oct == L_MAX) ? L_MAX : r_oct + 4'd1) :
                     w_dn_ev ? ((r_oct == L_MIN) ? L_MIN : r_oct - 4'd1) : r_oct;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_sync   <= '0;
      r_note_valid <= 1'b0;
      r_note_idx   <= '0;
      r_seg_note   <= SEG_BLANK;
      r_oct        <= L_INIT;
      r_seg_oct    <= digit_to_seg(L_INIT);
    end else begin
      r_key_sync   <= {r_key_sync[SYNC_STAGES-2:0], bus.key};
      r_note_valid <= |w_key;
      r_note_idx   <= w_idx;
      r_seg_note   <= (|w_key) ? note_to_seg(w_idx) : SEG_BLANK;
      r_oct        <= w_oct_nxt;
      r_seg_oct    <= digit_to_seg(r_oct);
    end
  end
  assign bus.note_valid = r_note_valid;
  assign bus.note_idx   = r_note_idx;
  assign bus.seg_note   = r_seg_note;
  assign bus.octave     = r_oct;
  assign bus.seg_oct    = r_seg_oct;
endmodule

// File: tb/tb_note_octave_seg.sv
// tb_note_octave_seg: directed + random stimulus against a cycle-level behavioural model
module tb_note_octave_seg;
  localparam int S  = 2;
  localparam int DB = 4;
  localparam logic [6:0] DIG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [6:0] LET [7]  = '{7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h77, 7'h7C};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  note_octave_seg_if bus ();
  note_octave_seg #(.SYNC_STAGES(S), .DB_CYCLES(DB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  logic [6:0] hk[$];
  logic       hu[$];
  logic       hd[$];
  logic [DB-1:0] win_u, win_d;
  int   nu, nd;
  logic lu, ld, ru, rd;
  logic e_valid;
  logic [2:0] e_idx;
  logic [6:0] e_seg_note, e_seg_oct;
  logic [3:0] e_oct;

  function automatic logic [3:0] next_oct(input logic [3:0] o, input logic u, input logic d);
    if (u && !d) begin
`ifdef OCT_WRAP_EN
      return (o == 7) ? 4'd0 : o + 4'd1;
`else
      return (o < 7) ? o + 4'd1 : 4'd7;
`endif
    end
    if (d && !u) begin
`ifdef OCT_WRAP_EN
      return (o == 0) ? 4'd7 : o - 4'd1;
`else
      return (o > 0) ? o - 4'd1 : 4'd0;
`endif
    end
    return o;
  endfunction

  // Predicts the state just after the coming clock edge from the inputs in force before it.
  task automatic model_edge();
    logic [6:0] sk;
    logic s_u, s_d, fu, fd;
    if (rst) begin
      hk.delete(); hu.delete(); hd.delete();
      nu = 0; nd = 0; win_u = '0; win_d = '0;
      lu = 0; ld = 0; ru = 0; rd = 0;
      e_valid = 0; e_idx = 0; e_seg_note = 7'h00; e_oct = 4; e_seg_oct = DIG[4];
      return;
    end
    hk.push_back(bus.key); hu.push_back(bus.up); hd.push_back(bus.down);
    sk  = (hk.size() > S) ? hk[hk.size()-1-S] : 7'h00;
    s_u = (hu.size() > S) ? hu[hu.size()-1-S] : 1'b0;
    s_d = (hd.size() > S) ? hd[hd.size()-1-S] : 1'b0;
    if (hk.size() > S + 1) begin
      void'(hk.pop_front()); void'(hu.pop_front()); void'(hd.pop_front());
    end
    e_valid = |sk;
    e_idx = 0;
    for (int i = 6; i >= 0; i--) if (sk[i]) e_idx = 3'(i);
    e_seg_note = e_valid ? LET[e_idx] : 7'h00;
    e_seg_oct = DIG[e_oct];
    e_oct = next_oct(e_oct, ru, rd);
    win_u = {win_u[DB-2:0], s_u}; nu = (nu < DB) ? nu + 1 : DB;
    win_d = {win_d[DB-2:0], s_d}; nd = (nd < DB) ? nd + 1 : DB;
    fu = (nu == DB) && (win_u == {DB{~lu}});
    fd = (nd == DB) && (win_d == {DB{~ld}});
    ru = fu && !lu; rd = fd && !ld;
    lu = lu ^ fu; ld = ld ^ fd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      model_edge();
      @(posedge clk);
      #1;
      chk("note_valid", 32'(bus.note_valid), 32'(e_valid));
      chk("note_idx", 32'(bus.note_idx), 32'(e_idx));
      chk("seg_note", 32'(bus.seg_note), 32'(e_seg_note));
      chk("octave", 32'(bus.octave), 32'(e_oct));
      chk("seg_oct", 32'(bus.seg_oct), 32'(e_seg_oct));
    end
  endtask

  initial begin
    logic [3:0] exp_oct [4];
`ifdef OCT_WRAP_EN
    exp_oct = '{4'd5, 4'd6, 4'd7, 4'd0};
`else
    exp_oct = '{4'd5, 4'd6, 4'd7, 4'd7};
`endif
    bus.key = '0; bus.up = 0; bus.down = 0;
    step(3);
    rst = 0;
    chk("rst_octave", 32'(bus.octave), 32'd4);
    chk("rst_seg_oct", 32'(bus.seg_oct), 32'h66);
    chk("rst_seg_note", 32'(bus.seg_note), 32'h00);
    chk("rst_valid", 32'(bus.note_valid), 32'd0);
    bus.key = 7'b0000001; step(3);
    chk("key_c_idx", 32'(bus.note_idx), 32'd0);
    chk("key_c_seg", 32'(bus.seg_note), 32'h39);
    chk("key_c_valid", 32'(bus.note_valid), 32'd1);
    bus.key = 7'b0010100; step(3);
    chk("key_e_idx", 32'(bus.note_idx), 32'd2);
    chk("key_e_seg", 32'(bus.seg_note), 32'h79);
    bus.key = 7'b0000000; step(3);
    chk("key_none_seg", 32'(bus.seg_note), 32'h00);
    chk("key_none_valid", 32'(bus.note_valid), 32'd0);
    for (int p = 0; p < 4; p++) begin
      bus.up = 1; step(10);
      bus.up = 0; step(10);
      chk("up_press_oct", 32'(bus.octave), 32'(exp_oct[p]));
    end
    chk("up_sat_seg_oct", 32'(bus.seg_oct), 32'(DIG[exp_oct[3]]));
    for (int p = 0; p < 3; p++) begin
      bus.up = 1; step(2);
      bus.up = 0; step(1);
    end
    step(10);
    chk("glitch_oct", 32'(bus.octave), 32'(exp_oct[3]));
    rst = 1; step(2); rst = 0;
    bus.up = 1; bus.down = 1; step(10);
    bus.up = 0; bus.down = 0; step(10);
    chk("both_oct", 32'(bus.octave), 32'd4);
    bus.key = 7'b0100000; step(3);
    bus.up = 1; step(10);
    bus.up = 0; step(3);
    chk("hold_idx", 32'(bus.note_idx), 32'd5);
    chk("hold_seg", 32'(bus.seg_note), 32'h77);
    chk("hold_oct", 32'(bus.octave), 32'd5);
    rst = 1; step(1); rst = 0;
    chk("midrst_oct", 32'(bus.octave), 32'd4);
    step(3);
    chk("midrst_seg", 32'(bus.seg_note), 32'h77);
    bus.up = 1; step(5);
    rst = 1; step(1); rst = 0;
    step(8);
    chk("rst_midpress_oct", 32'(bus.octave), 32'd5);
    bus.up = 0; step(8);
    for (int s = 0; s < 150; s++) begin
      bus.key  = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
      bus.up   = 1'($urandom_range(0, 1));
      bus.down = 1'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 40) == 0);
      step($urandom_range(1, 8));
      rst = 0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_octave_seg.md
# note_octave_seg

Clocked, parametrised successor to the combinational note-to-segment decoder in the electronic piano front panel. It synchronises seven note keys (C..B) and debounces the octave up/down buttons. It holds a saturating octave register and drives two registered seven-segment digits: note letter and octave number. The note index and octave outputs also feed the tone generator.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser flops on every async input (≥2)
- DB_CYCLES, 65536: consecutive stable cycles before a debounced button level flips (≥2)
- OCT_MIN, 0: lowest octave (0..9)
- OCT_MAX, 7: highest octave (OCT_MIN..9)
- OCT_INIT, 4: octave after reset (OCT_MIN..OCT_MAX)

Ports (all synchronous to clk; reset is synchronous, active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- key  in  7  async note keys, active-high; bit0=C, 1=D, 2=E, 3=F, 4=G, 5=A, 6=B
- up  in  1  async octave-up button, active-high
- down  in  1  async octave-down button, active-high
- seg_note  out  7  note letter segments {g,f,e,d,c,b,a}, active-high
- seg_oct  out  7  octave digit segments {g,f,e,d,c,b,a}, active-high
- note_valid  out  1  a key is pressed
- note_idx  out  3  index of the selected key (0..6)
- octave  out  4  current octave

## Operation
- Keys: SYNC_STAGES-flop synchroniser, then a priority select with lowest index winning (C over D … over B).
- Registered outputs:
  - note_valid = OR of synced keys.
  - note_idx = winner, or 0 when none pressed.
  - seg_note = letter of the winner, or 0x00 (blank) when none pressed.
- Letter codes: C=0x39, d=0x5E, E=0x79, F=0x71, G=0x3D, A=0x77, b=0x7C.
- Buttons: each is synchronised, then goes through a debouncer.
  - The counter increments while the synced level differs from the debounced state and clears when they match.
  - When the count reaches DB_CYCLES-1 while still differing, the debounced state flips and the counter clears.
  - Only a rising edge of the debounced level is an event.
- Octave events:
  - up event: octave+1, saturating at OCT_MAX.
  - down event: octave-1, saturating at OCT_MIN.
  - up and down events in the same cycle: no change.
  - Held buttons do not repeat.
- seg_oct = digit code of octave. Digit codes: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
- Key path and button path are independent; an octave change while a key is held leaves note outputs unchanged.

## Timing
- Reset values:
  - octave=OCT_INIT, seg_oct=digit(OCT_INIT)
  - note_valid=0, note_idx=0, seg_note=0x00
  - debounced levels=0, debounce counters=0, synchroniser flops=0
- Reset mid-press: a button still high after rst deasserts yields an event after DB_CYCLES stable cycles, because the debounced level restarts at 0.
- Key latency: key edge → note outputs updated SYNC_STAGES+1 clock edges later.
- Button latency, for a clean press:
  - Debounced flip at edge SYNC_STAGES+DB_CYCLES.
  - octave updates the next edge.
  - seg_oct updates one edge after octave.
- Glitch rule: a bounce shorter than DB_CYCLES cycles resets the counter and produces no event.

## Configuration
- OCT_WRAP_EN:
  - Defined: up at OCT_MAX wraps to OCT_MIN; down at OCT_MIN wraps to OCT_MAX.
  - Undefined (default): saturate as described in Operation.
  - Simultaneous up and down events give no change in both builds.

## Structure
- note_seg_pkg holds:
  - SEG_W=7
  - letter constants SEG_C..SEG_B, digit constants SEG_0..SEG_9, SEG_BLANK
  - the function note_to_seg(idx) and the function digit_to_seg(n)
- Sub-module btn_debounce (params SYNC_STAGES, DB_CYCLES; ports clk, rst, din, level, rise) is instantiated twice, once each for up and down.
- The key synchroniser, priority select and octave register live in the top.

## Test plan
Bench parameters: DB_CYCLES=4, SYNC_STAGES=2, defaults otherwise.
- Reset held 3 cycles → octave=4, seg_oct=0x66, seg_note=0x00, note_valid=0.
- key=7'b0000001 → 3 edges later note_idx=0, seg_note=0x39, note_valid=1. Then key=7'b0010100 → note_idx=2, seg_note=0x79. Then key=0 → seg_note=0x00, note_valid=0.
- up held 10 cycles, released, repeated 4 times → octave 5, 6, 7, 7 (saturates); seg_oct=0x07. With OCT_WRAP_EN the fourth press gives 0 and seg_oct=0x3F.
- up pulsed high for 2 cycles, 3 times, separated by 1-cycle lows → no octave change.
- up and down rising together and held 10 cycles → octave unchanged at 4.
- key[5] held; up pressed → note_idx stays 5, seg_note stays 0x77; octave becomes 5. Then rst pulse mid-hold → octave=4 and, 3 edges after release, seg_note=0x77 again.
